// File: rtl/tl_get_responder_pkg.sv
// Shared TileLink-UL constants, FSM encoding and burst-length helper for the Get responder.
package tl_get_responder_pkg;

    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    // Number of data beats in a response of 2^lg_size bytes on a 2^beat_lg byte bus.
    function automatic logic [11:0] lg_size_to_beats(input logic [3:0] lg_size, input int beat_lg);
        if (int'(lg_size) <= beat_lg) begin
            return 12'd1;
        end
        return 12'd1 << (int'(lg_size) - beat_lg);
    endfunction

endpackage

// File: rtl/tl_get_responder_beat_skid_fifo.sv
// Two-entry registered beat FIFO between the memory read port and channel D.
module beat_skid_fifo #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    // The producer never writes while full unless the head is being popped the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = wr_ptr_q ^ wr_en;
        rd_ptr_d = rd_ptr_q ^ rd_en;
        count_d  = count_q + {1'b0, wr_en} - {1'b0, rd_en};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/tl_get_responder.sv
// TileLink-UL Get responder: accepts A-channel Gets and streams AccessAckData bursts
// on channel D from a beat-addressed 1R1W memory with a backdoor load port.
module tl_get_responder
    import tl_get_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 32,
    parameter int SOURCE_WIDTH = 4,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 0,
    parameter int MAX_LG_SIZE  = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [2:0]               a_bits_opcode,
    input  logic [3:0]               a_bits_size,
    input  logic [SOURCE_WIDTH-1:0]  a_bits_source,
    input  logic [ADDR_WIDTH-1:0]    a_bits_address,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [2:0]               d_bits_opcode,
    output logic [3:0]               d_bits_size,
    output logic [SOURCE_WIDTH-1:0]  d_bits_source,
    output logic                     d_bits_denied,
    output logic [DATA_WIDTH-1:0]    d_bits_data,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam int         BEAT_LG    = $clog2(DATA_WIDTH / 8);
    localparam logic [3:0] MAX_SIZE_L = 4'(MAX_LG_SIZE);
    localparam logic [7:0] LAT_L      = 8'(LATENCY);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a source
    // holds valid and its payload stable until that edge, ready never waits on valid.
    state_e                    state_q, state_d;
    logic [7:0]                wait_cnt_q, wait_cnt_d;
    logic [3:0]                size_q, size_d;
    logic [SOURCE_WIDTH-1:0]   source_q, source_d;
    logic                      denied_q, denied_d;
    logic [11:0]               beats_q, beats_d;
    logic [IDX_W-1:0]          base_q, base_d;
    logic [11:0]               rd_cnt_q, rd_cnt_d;
    logic [11:0]               d_cnt_q, d_cnt_d;
    logic                      inflight_q, inflight_d;
    logic                      a_ready_q, a_ready_d;

    logic                      a_fire;
    logic                      d_fire;
    logic                      rd_issue;
    logic [2:0]                occupancy;
    logic [IDX_W-1:0]          rd_idx;
    logic [ADDR_WIDTH-1:0]     beat_addr;
    logic [ADDR_WIDTH-1:0]     low_mask;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH-1:0]     fifo_wdata;
    logic [DATA_WIDTH-1:0]     fifo_rdata;
    logic [1:0]                fifo_count;

    assign a_fire = a_valid && a_ready_q;
    assign d_fire = d_valid && d_ready;

    // Beats already buffered or on their way, minus the one leaving this cycle, must
    // leave room in the two-entry FIFO before another read is launched.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, d_fire};
    assign rd_issue  = (state_q == ST_BURST) && (rd_cnt_q < beats_q) && (occupancy < 3'd2);
    assign rd_idx    = base_q + IDX_W'(rd_cnt_q);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        size_d     = size_q;
        source_d   = source_q;
        denied_d   = denied_q;
        beats_d    = beats_q;
        base_d     = base_q;
        rd_cnt_d   = rd_cnt_q;
        d_cnt_d    = d_cnt_q;
        inflight_d = rd_issue;

        // Burst base is the beat index aligned down to the burst length.
        beat_addr = a_bits_address >> BEAT_LG;
        low_mask  = '0;
        if (int'(a_bits_size) > BEAT_LG) begin
            low_mask = (ADDR_WIDTH'(1) << (int'(a_bits_size) - BEAT_LG)) - ADDR_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    size_d   = a_bits_size;
                    source_d = a_bits_source;
                    denied_d = (a_bits_opcode != TL_A_GET) || (a_bits_size > MAX_SIZE_L);
                    beats_d  = lg_size_to_beats(a_bits_size, BEAT_LG);
                    base_d   = IDX_W'(beat_addr & ~low_mask);
                    rd_cnt_d = 12'd0;
                    d_cnt_d  = 12'd0;
                    if (LATENCY > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = LAT_L;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 8'd1;
                if (wait_cnt_q == 8'd1) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 12'd1;
                end
                if (d_fire) begin
                    d_cnt_d = d_cnt_q + 12'd1;
                    if (d_cnt_q == beats_q - 12'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            size_q     <= 4'd0;
            source_q   <= '0;
            denied_q   <= 1'b0;
            beats_q    <= 12'd0;
            base_q     <= '0;
            rd_cnt_q   <= 12'd0;
            d_cnt_q    <= 12'd0;
            inflight_q <= 1'b0;
            a_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            size_q     <= size_d;
            source_q   <= source_d;
            denied_q   <= denied_d;
            beats_q    <= beats_d;
            base_q     <= base_d;
            rd_cnt_q   <= rd_cnt_d;
            d_cnt_q    <= d_cnt_d;
            inflight_q <= inflight_d;
            a_ready_q  <= a_ready_d;
        end
    end

    // Contents survive reset; a read of an index being loaded returns the old word.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (rd_issue) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign fifo_wdata = denied_q ? '0 : rdata_q;

    beat_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_beat_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .wr_en   (inflight_q),
        .wr_data (fifo_wdata),
        .rd_en   (d_fire),
        .rd_data (fifo_rdata),
        .count   (fifo_count)
    );

    assign a_ready       = a_ready_q;
    assign d_valid       = (fifo_count != 2'd0);
    assign d_bits_opcode = TL_D_ACCESS_ACK_DATA;
    assign d_bits_size   = size_q;
    assign d_bits_source = source_q;
    assign d_bits_denied = denied_q;
    assign d_bits_data   = fifo_rdata;

endmodule

// File: tb/tb_tl_get_responder.sv
// Directed scoreboard bench for tl_get_responder: instance 0 has LATENCY 0, instance 1 LATENCY 3.
module tb_tl_get_responder;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;
    localparam int EW    = 1 + 4 + SW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid   [2];
    logic          a_ready   [2];
    logic [2:0]    a_opcode  [2];
    logic [3:0]    a_size    [2];
    logic [SW-1:0] a_source  [2];
    logic [AW-1:0] a_address [2];
    logic          d_valid   [2];
    logic          d_ready   [2];
    logic [2:0]    d_opcode  [2];
    logic [3:0]    d_size    [2];
    logic [SW-1:0] d_source  [2];
    logic          d_denied  [2];
    logic [DW-1:0] d_data    [2];
    logic          load_en   [2];
    logic [IW-1:0] load_addr [2];
    logic [DW-1:0] load_data [2];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int            n_checks = 0;
    int            n_errors = 0;

    localparam logic [DW-1:0] BEAT_A  = {4'hA, 124'h0};
    localparam logic [DW-1:0] BEAT_B  = {4'hB, 124'h0};
    localparam logic [DW-1:0] BEAT_C  = {4'hC, 124'h0};
    localparam logic [DW-1:0] BEAT_D  = {4'hD, 124'h0};
    localparam logic [DW-1:0] BEAT_1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    tl_get_responder #(.LATENCY(0)) u_dut0 (
        .clock(clk), .reset(rst_n),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_bits_opcode(a_opcode[0]),
        .a_bits_size(a_size[0]), .a_bits_source(a_source[0]), .a_bits_address(a_address[0]),
        .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_bits_opcode(d_opcode[0]),
        .d_bits_size(d_size[0]), .d_bits_source(d_source[0]), .d_bits_denied(d_denied[0]),
        .d_bits_data(d_data[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0])
    );

    tl_get_responder #(.LATENCY(3)) u_dut1 (
        .clock(clk), .reset(rst_n),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_bits_opcode(a_opcode[1]),
        .a_bits_size(a_size[1]), .a_bits_source(a_source[1]), .a_bits_address(a_address[1]),
        .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_bits_opcode(d_opcode[1]),
        .d_bits_size(d_size[1]), .d_bits_source(d_source[1]), .d_bits_denied(d_denied[1]),
        .d_bits_data(d_data[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1])
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic den, input logic [3:0] sz,
                                          input logic [SW-1:0] src, input logic [DW-1:0] dat);
        return {den, sz, src, dat};
    endfunction

    task automatic push(input int u, input logic [EW-1:0] e);
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input int u, input logic [IW-1:0] idx, input logic [DW-1:0] dat);
        @(posedge clk); #1;
        load_en[u]   = 1'b1;
        load_addr[u] = idx;
        load_data[u] = dat;
        @(posedge clk); #1;
        load_en[u]   = 1'b0;
    endtask

    // Issues one A request; reports in which cycle after the accept d_valid first rose
    // and a_ready came back (1 = the cycle right after the accept edge, -1 = never).
    task automatic send_a(input int u, input logic [2:0] op, input logic [3:0] sz,
                          input logic [SW-1:0] src, input logic [AW-1:0] addr,
                          output int first_valid, output int ready_again);
        bit accepted;
        first_valid = -1;
        ready_again = -1;
        accepted    = 1'b0;
        @(posedge clk); #1;
        a_valid[u]   = 1'b1;
        a_opcode[u]  = op;
        a_size[u]    = sz;
        a_source[u]  = src;
        a_address[u] = addr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ready[u]) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_accept_timeout%0d: got a_ready 0 expected 1", u);
        end
        @(posedge clk); #1;
        a_valid[u] = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (first_valid < 0 && d_valid[u]) first_valid = i;
            if (a_ready[u]) begin
                ready_again = i;
                break;
            end
        end
    endtask

    task automatic toggle_d_ready(input int u, input int n);
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            d_ready[u] = pat[i % 4];
        end
        @(posedge clk); #1;
        d_ready[u] = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor(input int u);
        logic          held_v;
        logic [EW-1:0] held;
        logic [EW-1:0] beat;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            beat = {d_denied[u], d_size[u], d_source[u], d_data[u]};
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check($sformatf("stall_valid%0d", u), {{(EW-1){1'b0}}, d_valid[u]}, 1);
                    check($sformatf("stall_stable%0d", u), beat, held);
                end
                if (d_valid[u] && d_ready[u]) begin
                    check($sformatf("d_opcode%0d", u), {{(EW-3){1'b0}}, d_opcode[u]}, 1);
                    if ((u == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat%0d: got %h expected no beat", u, beat);
                    end else if (u == 0) begin
                        check("d_beat0", beat, exp_q0.pop_front());
                    end else begin
                        check("d_beat1", beat, exp_q1.pop_front());
                    end
                end
                held_v = d_valid[u] && !d_ready[u];
                held   = beat;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int fv, ra;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            a_valid[u] = 1'b0; a_opcode[u] = '0; a_size[u] = '0; a_source[u] = '0;
            a_address[u] = '0; d_ready[u] = 1'b1; load_en[u] = 1'b0; load_addr[u] = '0;
            load_data[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_a_ready%0d", u), {{(EW-1){1'b0}}, a_ready[u]}, 1);
            check($sformatf("rst_d_valid%0d", u), {{(EW-1){1'b0}}, d_valid[u]}, 0);
            check($sformatf("rst_d_fields%0d", u),
                  {d_denied[u], d_size[u], d_source[u], d_data[u]}, 0);
        end

        load(0, 10'h040, BEAT_A);
        load(0, 10'h041, BEAT_B);
        load(0, 10'h042, BEAT_C);
        load(0, 10'h043, BEAT_D);
        load(0, 10'h001, BEAT_1);
        load(1, 10'h3FC, 128'hCAFE_03FC);
        load(1, 10'h3FD, 128'hCAFE_03FD);
        load(1, 10'h3FE, 128'hCAFE_03FE);
        load(1, 10'h3FF, 128'hCAFE_03FF);

        // 64-byte Get, no backpressure
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_A));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_B));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_C));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_D));
        send_a(0, 3'd4, 4'd6, 4'd0, 32'h400, fv, ra);
        check("get64_first_valid", fv, 3);
        check("get64_a_ready_again", ra, 7);
        check("get64_drain", exp_q0.size(), 0);

        // same Get with d_ready toggling 1-0-0-1
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_A));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_B));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_C));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_D));
        fork
            send_a(0, 3'd4, 4'd6, 4'd0, 32'h400, fv, ra);
            toggle_d_ready(0, 24);
        join
        check("stall_first_valid", fv, 3);
        check("stall_drain", exp_q0.size(), 0);

        // sub-beat Get: single beat
        push(0, mk(1'b0, 4'd3, 4'd2, BEAT_1));
        send_a(0, 3'd4, 4'd3, 4'd2, 32'h18, fv, ra);
        check("single_first_valid", fv, 3);
        check("single_a_ready_again", ra, 4);
        check("single_drain", exp_q0.size(), 0);

        // PutFull opcode: denied, zero data, still 4 beats
        for (int i = 0; i < 4; i++) push(0, mk(1'b1, 4'd6, 4'd3, '0));
        send_a(0, 3'd0, 4'd6, 4'd3, 32'h400, fv, ra);
        check("put_a_ready_again", ra, 7);
        check("put_drain", exp_q0.size(), 0);

        // oversize Get: denied with 8 beats
        for (int i = 0; i < 8; i++) push(0, mk(1'b1, 4'd7, 4'd4, '0));
        send_a(0, 3'd4, 4'd7, 4'd4, 32'h400, fv, ra);
        check("oversize_a_ready_again", ra, 11);
        check("oversize_drain", exp_q0.size(), 0);

        // LATENCY 3 with index wrap 0x3FFC -> 0x3FC
        push(1, mk(1'b0, 4'd6, 4'd1, 128'hCAFE_03FC));
        push(1, mk(1'b0, 4'd6, 4'd1, 128'hCAFE_03FD));
        push(1, mk(1'b0, 4'd6, 4'd1, 128'hCAFE_03FE));
        push(1, mk(1'b0, 4'd6, 4'd1, 128'hCAFE_03FF));
        send_a(1, 3'd4, 4'd6, 4'd1, 32'h3FFC0, fv, ra);
        check("lat3_first_valid", fv, 6);
        check("lat3_a_ready_again", ra, 10);
        check("lat3_drain", exp_q1.size(), 0);

        // reset after the second beat of a burst
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_A));
        push(0, mk(1'b0, 4'd6, 4'd0, BEAT_B));
        @(posedge clk); #1;
        a_valid[0] = 1'b1; a_opcode[0] = 3'd4; a_size[0] = 4'd6;
        a_source[0] = 4'd0; a_address[0] = 32'h400;
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (exp_q0.size() == 0) break;
        end
        check("rst_mid_two_beats", exp_q0.size(), 0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_d_valid", {{(EW-1){1'b0}}, d_valid[0]}, 0);
        check("rst_mid_a_ready", {{(EW-1){1'b0}}, a_ready[0]}, 1);
        repeat (10) @(posedge clk);

        push(0, mk(1'b0, 4'd6, 4'd7, BEAT_A));
        push(0, mk(1'b0, 4'd6, 4'd7, BEAT_B));
        push(0, mk(1'b0, 4'd6, 4'd7, BEAT_C));
        push(0, mk(1'b0, 4'd6, 4'd7, BEAT_D));
        send_a(0, 3'd4, 4'd6, 4'd7, 32'h400, fv, ra);
        check("post_rst_first_valid", fv, 3);
        check("post_rst_a_ready_again", ra, 7);
        check("post_rst_drain", exp_q0.size(), 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
